// File: rtl/fil_win_acc_pkg.sv
// Shared definitions for the serial bit filter and its downstream window accumulator.
package fil_win_acc_pkg;

    localparam int FIL_WIN = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/fil_win_acc_win_cnt.sv
// Modulo-WIN sample counter with enable, sync clear and a wrap pulse on the last sample.
module win_cnt
    import fil_win_acc_pkg::*;
#(
    parameter  int WIN = FIL_WIN,
    localparam int CW  = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    // Wrap is combinational so the accumulator sees the window end in the same cycle.
    assign wrap = en && (cnt == CW'(WIN - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fil_win_acc.sv
// Counts ones of the filter sum stream over WIN enabled samples and presents each
// window count on a one-deep valid/ready slot with a sticky drop flag.
//
//  state      | meaning
//  SLOT_EMPTY | no result pending, res_valid low
//  SLOT_FULL  | result held on res_data until accepted
module fil_win_acc
    import fil_win_acc_pkg::*;
#(
    parameter  int WIN = FIL_WIN,
    localparam int CW  = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          bit_en,
    input  logic          bit_in,
    output logic [CW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          ovf,
    output logic [CW-1:0] win_idx
);

    slot_e         slot;
    logic [CW-1:0] acc;
    logic [CW-1:0] result;
    logic          win_end;
    logic          accept;

    win_cnt #(.WIN(WIN)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (bit_en),
        .cnt  (win_idx),
        .wrap (win_end)
    );

    // acc stays below WIN, so adding the final bit still fits CW.
    assign result    = acc + CW'(bit_in);
    assign accept    = res_valid && res_ready;
    assign res_valid = (slot == SLOT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= SLOT_EMPTY;
            acc      <= '0;
            res_data <= '0;
            ovf      <= 1'b0;
        end else if (clr) begin
            slot <= SLOT_EMPTY;
            acc  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (bit_en) begin
                acc <= win_end ? '0 : result;
            end
            case (slot)
                SLOT_EMPTY: begin
                    if (win_end) begin
                        res_data <= result;
                        slot     <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (accept) begin
                        if (win_end) begin
                            res_data <= result;
                        end else begin
                            slot <= SLOT_EMPTY;
                        end
                    end else if (win_end) begin
                        ovf <= 1'b1;
                    end
                end
                default: slot <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fil_win_acc.sv
// Directed bench for fil_win_acc with a scoreboard of expected window counts.
module tb_fil_win_acc;

    localparam int WIN = 16;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          rst, clr, bit_en, bit_in, res_ready;
    logic [CW-1:0] res_data, win_idx;
    logic          res_valid, ovf;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    fil_win_acc #(.WIN(WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bit_en    (bit_en),
        .bit_in    (bit_in),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .ovf       (ovf),
        .win_idx   (win_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle: inputs set after the edge, consumed at the next edge.
    task automatic cyc(input logic en, input logic b);
        bit_en = en;
        bit_in = b;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        bit_in = 1'b0;
    endtask

    // Drive n enabled samples; the first `ones` of them are 1.
    task automatic samples(input int n, input int ones);
        for (int i = 0; i < n; i++) cyc(1'b1, i < ones);
    endtask

    always @(negedge clk) begin
        if (!rst && !clr && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                check("sb_res_data", 32'(res_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; bit_en = 1'b0; bit_in = 1'b0; res_ready = 1'b0;

        // 1: reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) cyc(1'b0, 1'b0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_idx", 32'(win_idx), 0);
        check("rst_data", 32'(res_data), 0);

        // 2: alternating bits every cycle, two back-to-back windows
        res_ready = 1'b1;
        exp_q.push_back(8);
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN - 1) check("t2_valid_pre", 32'(res_valid), 0);
            cyc(1'b1, (i % 2) == 0);
        end
        check("t2_valid_17", 32'(res_valid), 1);
        check("t2_idx_wrap", 32'(win_idx), 0);
        exp_q.push_back(8);
        cyc(1'b1, 1'b1);
        check("t2_valid_drop", 32'(res_valid), 0);
        check("t2_idx_1", 32'(win_idx), 1);
        for (int i = 1; i < WIN; i++) cyc(1'b1, (i % 2) == 0);
        check("t2_valid_w2", 32'(res_valid), 1);
        cyc(1'b0, 1'b0);
        check("t2_valid_idle", 32'(res_valid), 0);

        // 3: sparse strobe, full-scale count
        exp_q.push_back(16);
        for (int i = 0; i < WIN; i++) begin
            cyc(1'b1, 1'b1);
            if (i < WIN - 1) begin
                cyc(1'b0, 1'b1);
                cyc(1'b0, 1'b0);
            end
        end
        check("t3_valid", 32'(res_valid), 1);
        check("t3_data_full", 32'(res_data), 16);
        cyc(1'b0, 1'b0);

        // 4: consumer stalled across two windows
        res_ready = 1'b0;
        exp_q.push_back(5);
        samples(WIN, 5);
        check("t4_valid_a", 32'(res_valid), 1);
        check("t4_ovf_a", 32'(ovf), 0);
        samples(WIN, 9);
        check("t4_ovf_b", 32'(ovf), 1);
        check("t4_data_held", 32'(res_data), 5);
        res_ready = 1'b1;
        cyc(1'b0, 1'b0);
        check("t4_valid_after", 32'(res_valid), 0);
        check("t4_ovf_sticky", 32'(ovf), 1);
        clr = 1'b1;
        cyc(1'b0, 1'b0);
        clr = 1'b0;
        check("t4_ovf_clr", 32'(ovf), 0);

        // 5: window end coincides with accept
        res_ready = 1'b0;
        exp_q.push_back(3);
        samples(WIN, 3);
        check("t5_data_3", 32'(res_data), 3);
        exp_q.push_back(7);
        samples(WIN - 1, 7);
        res_ready = 1'b1;
        cyc(1'b1, 1'b0);
        check("t5_valid_b2b", 32'(res_valid), 1);
        check("t5_data_7", 32'(res_data), 7);
        check("t5_ovf", 32'(ovf), 0);
        cyc(1'b0, 1'b0);
        check("t5_valid_end", 32'(res_valid), 0);

        // 6a: clr mid-window with FULL slot and ovf set
        res_ready = 1'b0;
        samples(WIN, 6);
        samples(WIN, 2);
        samples(10, 3);
        check("t6_idx_10", 32'(win_idx), 10);
        check("t6_ovf_pre", 32'(ovf), 1);
        clr = 1'b1;
        cyc(1'b1, 1'b1);
        clr = 1'b0;
        check("t6_clr_valid", 32'(res_valid), 0);
        check("t6_clr_ovf", 32'(ovf), 0);
        check("t6_clr_idx", 32'(win_idx), 0);
        check("t6_clr_data", 32'(res_data), 6);
        res_ready = 1'b1;
        exp_q.push_back(4);
        samples(WIN, 4);
        check("t6_data_4", 32'(res_data), 4);
        cyc(1'b0, 1'b0);

        // 6b: same with rst
        res_ready = 1'b0;
        samples(WIN, 6);
        samples(WIN, 2);
        samples(10, 3);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        check("t6r_valid", 32'(res_valid), 0);
        check("t6r_ovf", 32'(ovf), 0);
        check("t6r_idx", 32'(win_idx), 0);
        check("t6r_data", 32'(res_data), 0);
        res_ready = 1'b1;
        exp_q.push_back(4);
        samples(WIN, 4);
        check("t6r_data_4", 32'(res_data), 4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
